// File: rtl/imm_pkg.sv
// Shared encoding definitions for the instruction encoder: format codes, NOP word,
// immediate field widths and a signed-fit helper.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_SB = 3'd2,
    FMT_U  = 3'd3,
    FMT_UJ = 3'd4
  } fmt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned IMM_W_I  = 12;
  localparam int unsigned IMM_W_S  = 12;
  localparam int unsigned IMM_W_SB = 13;
  localparam int unsigned IMM_W_U  = 20 + 12;
  localparam int unsigned IMM_W_UJ = 21;

  // True when imm equals the sign extension of its low 'width' bits,
  // i.e. every bit from width-1 upward is identical.
  function automatic logic fits_signed(input logic [63:0] imm, input int unsigned width);
    logic [63:0] mask;
    logic [63:0] upper;
    mask  = {64{1'b1}} << (width - 1);
    upper = imm & mask;
    return (upper == 64'd0) || (upper == mask);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder; master drives requests, slave is the encoder.
interface imm_encoder_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_fmt;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [63:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_range_err;
  logic                 out_fmt_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_range_err, out_fmt_err, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_range_err, out_fmt_err, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational RV32 field placement: scatters register fields and immediate bits into
// the instruction word for each format; illegal formats yield the canonical NOP.
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr
);

  always_comb begin
    o_instr = NOP_INSTR;
    unique case (i_fmt)
      FMT_I:  o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S:  o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_SB: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], i_opcode};
      FMT_U:  o_instr = {i_imm[31:12], i_rd, i_opcode};
      FMT_UJ: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_instr = NOP_INSTR;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder: stage 1 registers fields and range-checks the
// immediate, stage 2 packs the word. ALIGN_CHECK_EN also flags odd SB/UJ offsets.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  imm_encoder_if.slave bus
);

  // Stage 1 state
  logic        r_s1_valid;
  logic [2:0]  r_s1_fmt;
  logic [6:0]  r_s1_opcode;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [2:0]  r_s1_funct3;
  logic [31:0] r_s1_imm;
  logic        r_s1_range_err;
  logic        r_s1_fmt_err;

  // Stage 2 state
  logic                 r_s2_valid;
  logic [31:0]          r_s2_instr;
  logic                 r_s2_range_err;
  logic                 r_s2_fmt_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_s1_advance;
  logic        w_range_err;
  logic        w_fmt_err;
  logic [31:0] w_packed;

  // Stage 1 moves on when stage 2 is empty or being drained this cycle.
  always_comb begin
    w_out_xfer   = r_s2_valid & bus.out_ready;
    w_s1_advance = r_s1_valid & (~r_s2_valid | bus.out_ready);
    bus.in_ready = ~r_s1_valid | w_s1_advance;
    w_in_xfer    = bus.in_valid & bus.in_ready;
  end

  always_comb begin
    w_range_err = 1'b0;
    w_fmt_err   = 1'b0;
    unique case (bus.in_fmt)
      FMT_I:  w_range_err = ~fits_signed(bus.in_imm, IMM_W_I);
      FMT_S:  w_range_err = ~fits_signed(bus.in_imm, IMM_W_S);
`ifdef ALIGN_CHECK_EN
      FMT_SB: w_range_err = ~fits_signed(bus.in_imm, IMM_W_SB) | bus.in_imm[0];
      FMT_UJ: w_range_err = ~fits_signed(bus.in_imm, IMM_W_UJ) | bus.in_imm[0];
`else
      FMT_SB: w_range_err = ~fits_signed(bus.in_imm, IMM_W_SB);
      FMT_UJ: w_range_err = ~fits_signed(bus.in_imm, IMM_W_UJ);
`endif
      FMT_U:  w_range_err = (bus.in_imm[11:0] != 12'd0) | ~fits_signed(bus.in_imm, IMM_W_U);
      default: w_fmt_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid     <= 1'b0;
      r_s1_fmt       <= 3'd0;
      r_s1_opcode    <= 7'd0;
      r_s1_rd        <= 5'd0;
      r_s1_rs1       <= 5'd0;
      r_s1_rs2       <= 5'd0;
      r_s1_funct3    <= 3'd0;
      r_s1_imm       <= 32'd0;
      r_s1_range_err <= 1'b0;
      r_s1_fmt_err   <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid     <= 1'b1;
        r_s1_fmt       <= bus.in_fmt;
        r_s1_opcode    <= bus.in_opcode;
        r_s1_rd        <= bus.in_rd;
        r_s1_rs1       <= bus.in_rs1;
        r_s1_rs2       <= bus.in_rs2;
        r_s1_funct3    <= bus.in_funct3;
        r_s1_imm       <= bus.in_imm[31:0];
        r_s1_range_err <= w_range_err;
        r_s1_fmt_err   <= w_fmt_err;
      end else if (w_s1_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  imm_pack u_pack (
    .i_fmt    (r_s1_fmt),
    .i_opcode (r_s1_opcode),
    .i_rd     (r_s1_rd),
    .i_rs1    (r_s1_rs1),
    .i_rs2    (r_s1_rs2),
    .i_funct3 (r_s1_funct3),
    .i_imm    (r_s1_imm),
    .o_instr  (w_packed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid     <= 1'b0;
      r_s2_instr     <= 32'd0;
      r_s2_range_err <= 1'b0;
      r_s2_fmt_err   <= 1'b0;
    end else begin
      if (w_s1_advance) begin
        r_s2_valid     <= 1'b1;
        r_s2_instr     <= w_packed;
        r_s2_range_err <= r_s1_range_err;
        r_s2_fmt_err   <= r_s1_fmt_err;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_out_xfer && (r_s2_range_err || r_s2_fmt_err) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.out_valid     = r_s2_valid;
  assign bus.out_instr     = r_s2_instr;
  assign bus.out_range_err = r_s2_range_err;
  assign bus.out_fmt_err   = r_s2_fmt_err;
  assign bus.err_count     = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder (narrow error counter to reach saturation).
module tb_imm_encoder;
  localparam int unsigned CW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [CW-1:0] exp_err;

  imm_encoder_if #(.ERR_CNT_W(CW)) bus ();

  imm_encoder #(.ERR_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [63:0] imm);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
  endtask

  // One isolated transaction: checks latency, word, flags and error counter.
  task automatic run_one(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [63:0] imm,
                         input logic [31:0] e_instr, input logic e_rerr, input logic e_ferr);
    @(negedge clk);
    drive(fmt, op, rd, rs1, rs2, f3, imm);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'(e_instr));
    chk({tag, "_rerr"}, 64'(bus.out_range_err), 64'(e_rerr));
    chk({tag, "_ferr"}, 64'(bus.out_fmt_err), 64'(e_ferr));
    if (e_rerr || e_ferr) exp_err = (exp_err == '1) ? exp_err : exp_err + 1'b1;
    @(posedge clk);
    #1 chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.err_count), 64'(exp_err));
  endtask

  logic [31:0] exp_q [8];
  logic        align_err;

  initial begin
    checks  = 0;
    errors  = 0;
    exp_err = '0;
`ifdef ALIGN_CHECK_EN
    align_err = 1'b1;
`else
    align_err = 1'b0;
`endif
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_range_err", 64'(bus.out_range_err), 64'd0);
    chk("rst_fmt_err", 64'(bus.out_fmt_err), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_one("i_m1",    3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1,    32'hFFF00093, 1'b0, 1'b0);
    run_one("i_m2048", 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd2048, 32'h80000093, 1'b0, 1'b0);
    run_one("s_m4",    3'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, -64'sd4,    32'hFE312E23, 1'b0, 1'b0);
    run_one("sb_8",    3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 64'd8,      32'h00000463, 1'b0, 1'b0);
    run_one("sb_m4",   3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd4,    32'hFE000EE3, 1'b0, 1'b0);
    run_one("uj_2048", 3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048,   32'h001000EF, 1'b0, 1'b0);
    run_one("u_ok",    3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345000, 32'h123452B7, 1'b0, 1'b0);
    run_one("i_2048",  3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048,   32'h80000093, 1'b1, 1'b0);
    chk("err_cnt_one", 64'(bus.err_count), 64'd1);
    run_one("sb_9",    3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 64'd9,      32'h00000463, align_err, 1'b0);
    run_one("u_low",   3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345001, 32'h123452B7, 1'b1, 1'b0);
    run_one("sb_4096", 3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 64'd4096,   32'h80000063, 1'b1, 1'b0);
    run_one("fmt7",    3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 64'd2048,   32'h00000013, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_one("sat", 3'd5, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 32'h00000013, 1'b0, 1'b1);
    end
    chk("err_cnt_sat", 64'(bus.err_count), 64'h7);

    // Back-to-back burst with out_ready toggling every cycle.
    begin
      int tx;
      int rx;
      logic saw_stall;
      tx = 0;
      rx = 0;
      saw_stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
        exp_q[i] = (32'(i) << 20) | (32'(i) << 15) | (32'(i + 1) << 7) | 32'h13;
      end
      for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
        @(negedge clk);
        bus.out_ready = (cyc % 2 == 0);
        bus.in_valid  = (tx < 8);
        drive(3'd0, 7'h13, 5'(tx + 1), 5'(tx), 5'd0, 3'd0, 64'(tx));
        #1;
        if (bus.out_valid && bus.out_ready) begin
          chk("burst_instr", 64'(bus.out_instr), 64'(exp_q[rx]));
          rx++;
        end else if (bus.out_valid) begin
          chk("burst_hold", 64'(bus.out_instr), 64'(exp_q[rx]));
        end
        if (bus.in_valid && bus.in_ready) tx++;
        if (!bus.in_ready) saw_stall = 1'b1;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("burst_rx", 64'(rx), 64'd8);
      chk("burst_tx", 64'(tx), 64'd8);
      chk("burst_stall", 64'(saw_stall), 64'd1);
      @(posedge clk);
      #1 chk("burst_empty", 64'(bus.out_valid), 64'd0);
    end

    // Fill both stages with out_ready low, then reset mid-flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    repeat (3) @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_err_count", 64'(bus.err_count), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_err = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_empty", 64'(bus.out_valid), 64'd0);
    run_one("post_rst", 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1, 32'hFFF00093, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
